// File: rtl/id_pipe_if.sv
// Handshake and payload bundle between IF, the id_pipe decode stage and EX.
interface id_pipe_if #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH = 16
);
  // IF -> ID
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_WIDTH-1:0]  in_pc;
  logic [31:0]          in_inst;
  logic                 flush;

  // Register-file read port
  logic                 rs1_re;
  logic                 rs2_re;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic [31:0]          rs1_data_i;
  logic [31:0]          rs2_data_i;

  // ID/EX register
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_WIDTH-1:0]  out_pc;
  logic [6:0]           out_opcode;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic [31:0]          out_imm;
  logic [31:0]          out_rs1_data;
  logic [31:0]          out_rs2_data;
  logic                 out_rd_we;
  logic [4:0]           out_rd_addr;
  logic                 out_is_load;
  logic                 out_illegal;
  logic [CNT_WIDTH-1:0] stall_cycles;

  // Environment side: fetch, register file and EX
  modport master (
    output in_valid, in_pc, in_inst, flush, rs1_data_i, rs2_data_i, out_ready,
    input  in_ready, rs1_re, rs2_re, rs1_addr, rs2_addr,
    input  out_valid, out_pc, out_opcode, out_funct3, out_funct7, out_imm,
    input  out_rs1_data, out_rs2_data, out_rd_we, out_rd_addr, out_is_load,
    input  out_illegal, stall_cycles
  );

  // Decode stage side
  modport slave (
    input  in_valid, in_pc, in_inst, flush, rs1_data_i, rs2_data_i, out_ready,
    output in_ready, rs1_re, rs2_re, rs1_addr, rs2_addr,
    output out_valid, out_pc, out_opcode, out_funct3, out_funct7, out_imm,
    output out_rs1_data, out_rs2_data, out_rd_we, out_rd_addr, out_is_load,
    output out_illegal, stall_cycles
  );
endinterface

// File: rtl/id_pipe.sv
// RV32I decode stage: immediate generation, register-file read control,
// illegal detection, load-use stall and an ID/EX pipeline register.
module id_pipe #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter bit          HAZARD_CHECK = 1'b1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_pipe_if.slave     bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Decoded (combinational) fields
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rs1_re, dec_rs2_re, dec_rd_we, dec_is_load, dec_illegal;
  logic [RW-1:0]   dec_rd_addr;
  logic            slot_free, hazard;

  // ID/EX register state
  logic                 valid_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [6:0]           opcode_q;
  logic [2:0]           funct3_q;
  logic [6:0]           funct7_q;
  logic [XLEN-1:0]      imm_q;
  logic [XLEN-1:0]      rs1_data_q, rs2_data_q;
  logic                 rd_we_q;
  logic [RW-1:0]        rd_addr_q;
  logic                 is_load_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] stall_q;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];

  assign imm_i = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
  assign imm_s = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
  assign imm_b = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                  bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
  assign imm_u = {bus.in_inst[31:12], 12'b0};
  assign imm_j = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                  bus.in_inst[20], bus.in_inst[30:21], 1'b0};

  // Per-format decode; illegal encodings are neutralised so EX only sees a trap
  always_comb begin
    dec_imm     = '0;
    dec_rs1_re  = 1'b0;
    dec_rs2_re  = 1'b0;
    dec_rd_we   = 1'b0;
    dec_is_load = 1'b0;
    dec_illegal = 1'b0;
    dec_rd_addr = '0;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_imm   = imm_u;
        dec_rd_we = 1'b1;
      end
      OPC_JAL: begin
        dec_imm   = imm_j;
        dec_rd_we = 1'b1;
      end
      OPC_JALR: begin
        dec_imm    = imm_i;
        dec_rs1_re = 1'b1;
        dec_rd_we  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm    = imm_b;
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm     = imm_i;
        dec_rs1_re  = 1'b1;
        dec_rd_we   = 1'b1;
        dec_is_load = 1'b1;
      end
      OPC_STORE: begin
        dec_imm    = imm_s;
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
      end
      OPC_OPIMM: begin
        dec_rs1_re = 1'b1;
        dec_rd_we  = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm = {27'b0, bus.in_inst[24:20]};
          if (!(funct7 == 7'h00 || (funct3 == 3'b101 && funct7 == 7'h20)))
            dec_illegal = 1'b1;
        end else begin
          dec_imm = imm_i;
        end
      end
      OPC_OP: begin
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
        dec_rd_we  = 1'b1;
        if (funct7 != 7'h00 && funct7 != 7'h20)
          dec_illegal = 1'b1;
        else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
          dec_illegal = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        dec_imm = '0;
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_imm    = '0;
      dec_rs1_re = 1'b0;
      dec_rs2_re = 1'b0;
      dec_rd_we  = 1'b0;
    end
    if (bus.in_inst[11:7] == 5'd0)
      dec_rd_we = 1'b0;
    if (dec_rd_we)
      dec_rd_addr = bus.in_inst[11:7];
  end

  assign bus.rs1_re   = dec_rs1_re;
  assign bus.rs2_re   = dec_rs2_re;
  assign bus.rs1_addr = dec_rs1_re ? bus.in_inst[19:15] : 5'd0;
  assign bus.rs2_addr = dec_rs2_re ? bus.in_inst[24:20] : 5'd0;

  // Load-use detection against the instruction currently held in ID/EX
  assign slot_free = !valid_q || bus.out_ready;
  assign hazard    = HAZARD_CHECK && bus.in_valid && valid_q && is_load_q && rd_we_q &&
                     ((dec_rs1_re && bus.rs1_addr == rd_addr_q) ||
                      (dec_rs2_re && bus.rs2_addr == rd_addr_q));
  assign bus.in_ready = bus.flush || (slot_free && !hazard);

  // ID/EX pipeline register: flush, bubble, capture, drain or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      is_load_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (slot_free) begin
      if (hazard) begin
        valid_q <= 1'b0;
      end else if (bus.in_valid) begin
        valid_q    <= 1'b1;
        pc_q       <= bus.in_pc;
        opcode_q   <= opcode;
        funct3_q   <= funct3;
        funct7_q   <= funct7;
        imm_q      <= dec_imm;
        rs1_data_q <= dec_rs1_re ? bus.rs1_data_i : '0;
        rs2_data_q <= dec_rs2_re ? bus.rs2_data_i : '0;
        rd_we_q    <= dec_rd_we;
        rd_addr_q  <= dec_rd_addr;
        is_load_q  <= dec_is_load;
        illegal_q  <= dec_illegal;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Saturating count of cycles lost to load-use stalls
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (hazard && !bus.flush && !(&stall_q))
      stall_q <= stall_q + CNT_WIDTH'(1);
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_opcode   = opcode_q;
  assign bus.out_funct3   = funct3_q;
  assign bus.out_funct7   = funct7_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_rd_we    = rd_we_q;
  assign bus.out_rd_addr  = rd_addr_q;
  assign bus.out_is_load  = is_load_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered RV32I decode stage sitting between instruction fetch and EX. Generates full sign-extended immediates for all formats, register-file read controls, illegal-instruction flags and load-use hazard stalls. Results are captured in an ID/EX pipeline register with valid/ready handshakes on both sides, plus a flush input. A saturating stall counter supports performance analysis.

## Interface
- PC_WIDTH, 10, width of program counter fields
- HAZARD_CHECK, 1, 1 enables load-use stall logic; 0 ties hazard to 0
- CNT_WIDTH, 16, width of stall cycle counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  IF holds an instruction
- in_ready  out  1  ID accepts the instruction this cycle
- in_pc  in  PC_WIDTH  PC of the incoming instruction
- in_inst  in  32  raw instruction word
- flush  in  1  EX redirect; kills the ID/EX register and the incoming instruction
- rs1_re, rs2_re  out  1  register-file read enables (combinational from in_inst)
- rs1_addr, rs2_addr  out  5  read addresses: inst[19:15] and inst[24:20], forced to 0 when the matching read enable is 0
- rs1_data_i, rs2_data_i  in  32  register-file read data (same cycle)
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes this cycle
- out_pc  out  PC_WIDTH; out_opcode 7; out_funct3 3; out_funct7 7
- out_imm  out  32  sign-extended immediate
- out_rs1_data, out_rs2_data  out  32  captured operands (0 when not read)
- out_rd_we  out  1; out_rd_addr  out  5 (0 when rd_we is 0)
- out_is_load  out  1  opcode is LOAD
- out_illegal  out  1  undecodable instruction
- stall_cycles  out  CNT_WIDTH  saturating count of hazard-stall cycles

## Operation
- Decode (combinational on in_inst), immediates sign-extended from inst[31]:
  - LUI/AUIPC: U immediate {inst[31:12],12'b0}; rd_we=1.
  - JAL: J immediate; rd_we=1.
  - JALR: I immediate; rs1_re, rd_we.
  - BRANCH: B immediate; rs1_re, rs2_re.
  - LOAD: I immediate; rs1_re, rd_we, is_load.
  - STORE: S immediate; rs1_re, rs2_re.
  - OP-IMM: I immediate; shifts (funct3 001/101) use imm = {27'b0, inst[24:20]}.
  - OP: rs1_re, rs2_re, rd_we.
  - FENCE, SYSTEM: no reads or writes; imm=0.
- Illegal: opcode outside the set above; OP with funct7 not in {0x00, 0x20}; funct7=0x20 on an OP other than ADD/SUB(000) or SRL/SRA(101); OP-IMM shift with inst[31:25] not 0x00 (or 0x20 for SRAI). Illegal forces rd_we, rs1_re and rs2_re to 0 and imm to 0. The instruction still travels as valid so EX can trap.
- rd_addr == 0 forces rd_we to 0.
- slot_free = !out_valid | out_ready.
- hazard = HAZARD_CHECK & in_valid & out_valid & out_is_load & out_rd_we & ((rs1_re & rs1_addr==out_rd_addr) | (rs2_re & rs2_addr==out_rd_addr)).
- in_ready = flush | (slot_free & !hazard).
- Register update, in priority order:
  - rst: clear everything.
  - flush: out_valid<=0; the input is accepted and discarded.
  - slot_free & hazard: load a bubble (out_valid<=0, other fields unchanged).
  - slot_free & in_valid: capture the decoded fields, out_valid<=1.
  - slot_free & !in_valid: out_valid<=0.
  - Otherwise: hold all fields.
- stall_cycles increments each cycle with hazard & !flush and saturates at all-ones.

## Timing
- Latency: 1 cycle from in_valid&in_ready to out_valid.
- Throughput: 1 instruction per cycle when no hazard and out_ready=1.
- Load-use costs exactly 1 bubble: once the load leaves, hazard drops the next cycle.
- Reset (sync, sampled on clk): out_valid=0. All out_* data fields, out_illegal, out_is_load, out_rd_we and stall_cycles are 0.
- in_ready and rs*_re/addr are combinational from the current inputs and register state, including during reset.
- Fields stay stable while out_valid=1 and out_ready=0.
- flush together with rst: rst wins.
- flush together with hazard: flush wins; the counter does not increment.

## Test plan
- Reset for 2 cycles, then idle: every output reads 0, stall_cycles=0, in_ready=1.
- Input 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd_addr=1, out_rd_we=1, rs1_re=1 with rs1_addr=0.
- Input 0xFE312E23 (sw x3,-4(x2)) -> out_imm=0xFFFFFFFC, out_rd_we=0, out_rd_addr=0, rs1_addr=2, rs2_addr=3.
- Input 0x00812283 (lw x5,8(x2)), then 0x00128333 (add x6,x5,x1) -> one cycle with in_ready=0 and a bubble, then the add is issued; stall_cycles=1.
- Hold out_ready=0 for 3 cycles with a valid instruction -> in_ready=0 and output fields stable. Asserting flush -> out_valid=0 next cycle.
- Input 0x00000000 and 0x02208033 (funct7=0x01) -> out_illegal=1, out_rd_we=0, out_valid=1.
